// File: rtl/ntt_pkg.sv
// ntt_pkg
// Definitions shared by the NTT output path: the frame geometry used by the
// SDF top and the twiddle ROM, the per-bank state encoding of the reorder
// buffer, and the index bit-reversal helper.
package ntt_pkg;

    localparam int N_POINTS   = 8;
    localparam int ADDR_WIDTH = 3;

    // Widest index the bit-reversal helper handles.
    localparam int BITREV_MAX = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Reverses the low addr_width bits of addr; bits above addr_width are zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(
        input logic [BITREV_MAX-1:0] addr,
        input int                    addr_width
    );
        logic [BITREV_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX; i++) begin
            if (i < addr_width) begin
                r[i] = addr[addr_width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_reorder_bank.sv
// ntt_reorder_bank
// One frame of storage for the bit-reversal reorder buffer: a simple
// dual-port register file with one synchronous write port and one
// combinational read port.
//   clk      rising-edge clock
//   wr_en    write strobe
//   wr_addr  write index
//   wr_data  word to store
//   rd_addr  read index
//   rd_data  word at rd_addr (combinational)
module ntt_reorder_bank
    import ntt_pkg::*;
#(
    parameter int data_width = 64,
    parameter int n_points   = N_POINTS,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic [addr_width-1:0] rd_addr,
    output logic [data_width-1:0] rd_data
);

    // Contents are don't-care after reset; the bank state in the parent
    // decides which words are meaningful.
    logic [data_width-1:0] mem [n_points];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder
// Collects each frame emitted by the SDF NTT pipeline in bit-reversed index
// order and re-emits it in natural order. Two banks form a ping-pong buffer
// so one frame fills while the previous one drains.
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_data          coefficient from the SDF last stage (bit-reversed order)
//   in_valid         in_data valid
//   in_ready         buffer can accept in_data
//   out_data         coefficient in natural order (registered)
//   out_valid        out_data valid
//   out_ready        sink accepts out_data
//   out_last         final word (index n_points-1) of a frame
//   frame_done_tick  high in the cycle the last word of a frame is accepted
module ntt_bitrev_reorder
    import ntt_pkg::*;
#(
    parameter int data_width = 64,
    parameter int n_points   = N_POINTS,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done_tick
);

    localparam logic [addr_width-1:0] LAST_IDX = addr_width'(n_points - 1);

    logic                        wb_reg;
    logic                        rb_reg;
    logic [addr_width-1:0]       wcnt_reg;
    logic [addr_width-1:0]       rcnt_reg;
    bank_state_t [1:0]           bank_state;
    logic [1:0][data_width-1:0]  bank_rd_data;

    logic                        wr_fire;
    logic                        wr_wrap;
    logic                        rd_avail;
    logic                        rd_fire;
    logic                        rd_wrap;
    logic [addr_width-1:0]       rd_addr;

    // Writable only while the write bank holds no complete frame; depends on
    // registered state only, so a freshly drained bank opens the next cycle.
    assign in_ready = (bank_state[wb_reg] == BANK_EMPTY) ||
                      (bank_state[wb_reg] == BANK_FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign wr_wrap  = wr_fire && (wcnt_reg == LAST_IDX);

    // Issue into the output register when it is empty or being consumed.
    assign rd_avail = (bank_state[rb_reg] == BANK_FULL) ||
                      (bank_state[rb_reg] == BANK_DRAINING);
    assign rd_fire  = rd_avail && (!out_valid || out_ready);
    assign rd_wrap  = rd_fire && (rcnt_reg == LAST_IDX);

    // Word k of the natural-order output sits at position bitrev(k) of the
    // captured (bit-reversed) frame.
    assign rd_addr  = addr_width'(bitrev(BITREV_MAX'(rcnt_reg), addr_width));

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        bank_state_t state_reg;
        bank_state_t state_next;
        logic        wr_sel;
        logic        rd_sel;

        assign wr_sel = wr_fire && (wb_reg == 1'(gi));
        assign rd_sel = rd_fire && (rb_reg == 1'(gi));

        // Writes only hit EMPTY/FILLING banks and reads only FULL/DRAINING
        // banks, so wr_sel and rd_sel are never both set for one bank.
        always_comb begin
            state_next = state_reg;
            if (wr_sel) begin
                state_next = (wcnt_reg == LAST_IDX) ? BANK_FULL : BANK_FILLING;
            end else if (rd_sel) begin
                state_next = (rcnt_reg == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= BANK_EMPTY;
            end else begin
                state_reg <= state_next;
            end
        end

        assign bank_state[gi] = state_reg;

        ntt_reorder_bank #(
            .data_width (data_width),
            .n_points   (n_points),
            .addr_width (addr_width)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_sel),
            .wr_addr (wcnt_reg),
            .wr_data (in_data),
            .rd_addr (rd_addr),
            .rd_data (bank_rd_data[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg    <= 1'b0;
            rb_reg    <= 1'b0;
            wcnt_reg  <= '0;
            rcnt_reg  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_fire) begin
                wcnt_reg <= wcnt_reg + 1'b1;
                if (wr_wrap) begin
                    wb_reg <= ~wb_reg;
                end
            end
            if (rd_fire) begin
                rcnt_reg <= rcnt_reg + 1'b1;
                if (rd_wrap) begin
                    rb_reg <= ~rb_reg;
                end
            end
            if (rd_fire) begin
                out_valid <= 1'b1;
                out_data  <= bank_rd_data[rb_reg];
                out_last  <= rd_wrap;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign frame_done_tick = out_valid && out_ready && out_last;

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// tb_ntt_bitrev_reorder
// Directed bench for the bit-reversal reorder buffer. A negedge monitor keeps
// a frame-level model (collect 8 accepted words, emit them with the index
// bits reversed) and checks every accepted output word, out_last, the
// frame_done_tick pulse, hold stability under backpressure and reset values.
// Each test also checks the collected output against literal sequences.
module tb_ntt_bitrev_reorder;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done_tick;

    ntt_bitrev_reorder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .frame_done_tick (frame_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        bit          last;
    } exp_t;

    logic [63:0] fbuf[$];
    exp_t        exp_q[$];
    logic [63:0] got_q[$];
    int          cyc = 0;
    int          last_in_cyc = -1;
    int          first_out_cyc = -1;
    int          last_out_cyc = -1;
    int          ticks = 0;
    bit          saw_not_ready = 0;
    bit          hold_prev = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    // natural-order pattern of one frame whose input values are 0..7
    int pat[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // 3-bit index reversal by plain arithmetic
    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            chk("rst_tick", 64'(frame_done_tick), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            fbuf.delete();
            exp_q.delete();
            hold_prev = 0;
        end else begin
            if (in_valid && !in_ready) saw_not_ready = 1;
            if (in_valid && in_ready) begin
                fbuf.push_back(in_data);
                last_in_cyc = cyc;
                if (fbuf.size() == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        exp_t e;
                        e.d = fbuf[rev3(k)];
                        e.last = (k == 7);
                        exp_q.push_back(e);
                    end
                    fbuf.delete();
                end
            end
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", out_data, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("frame_done_tick", 64'(frame_done_tick), 64'(e.last));
                end
                got_q.push_back(out_data);
                $display("out word %0d last=%0b tick=%0b", out_data, out_last, frame_done_tick);
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (frame_done_tick) ticks++;
            end else if (frame_done_tick) begin
                chk("tick_without_accept", 64'(frame_done_tick), 64'd0);
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    // Drive count words base, base+1, ... optionally with random idle cycles.
    task automatic send_words(input int base, input int count, input bit gaps);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < count) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = 64'(base + i);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            budget++;
            if (budget > 3000) begin
                chk("send_timeout", 64'(i), 64'(count));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || fbuf.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(n < 1000), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        got_q.delete();
        first_out_cyc = -1;
        last_out_cyc = -1;
        saw_not_ready = 0;
    endtask

    // Compare collected outputs to nframes frames of pat, frame f offset base+8f.
    task automatic chk_frames(input string name, input int base, input int nframes);
        chk({name, "_count"}, 64'(got_q.size()), 64'(8 * nframes));
        for (int i = 0; i < got_q.size() && i < 8 * nframes; i++) begin
            chk(name, got_q[i], 64'(base + 8 * (i / 8) + pat[i % 8]));
        end
    endtask

    initial begin
        int t0;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single frame, sink always ready
        start_test();
        t0 = ticks;
        send_words(0, 8, 0);
        wait_drain();
        chk_frames("single", 0, 1);
        chk("single_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);
        chk("single_ticks", 64'(ticks - t0), 64'd1);

        // 2: back-to-back frames, no bubble, never stalled
        start_test();
        send_words(0, 16, 0);
        wait_drain();
        chk_frames("b2b", 0, 2);
        chk("b2b_no_bubble", 64'(last_out_cyc - first_out_cyc), 64'd15);
        chk("b2b_in_ready_low", 64'(saw_not_ready), 64'd0);

        // 3: backpressure after 3 words; a third frame is offered meanwhile
        start_test();
        fork
            send_words(0, 24, 0);
            begin
                n = 0;
                while (got_q.size() < 3 && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (30) @(posedge clk);
                #1;
                chk("bp_words_before_stall", 64'(got_q.size()), 64'd3);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_held_word", out_data, 64'd6);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_saw_stall", 64'(saw_not_ready), 64'd1);
        chk_frames("bp", 0, 3);

        // 4: random input gaps
        start_test();
        send_words(100, 8, 1);
        wait_drain();
        chk_frames("gaps", 100, 1);

        // 5: async reset mid-frame, then a clean frame
        start_test();
        send_words(50, 5, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_no_output", 64'(got_q.size()), 64'd0);
        start_test();
        t0 = ticks;
        send_words(0, 8, 0);
        wait_drain();
        chk_frames("after_reset", 0, 1);
        chk("after_reset_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);
        chk("after_reset_ticks", 64'(ticks - t0), 64'd1);

        // 6: three streamed frames, fill and drain completing together
        start_test();
        t0 = ticks;
        send_words(200, 24, 0);
        wait_drain();
        chk_frames("stream3", 200, 3);
        chk("stream3_ticks", 64'(ticks - t0), 64'd3);
        chk("stream3_no_bubble", 64'(last_out_cyc - first_out_cyc), 64'd23);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ntt_bitrev_reorder.md
Name: ntt_bitrev_reorder

Overview:
- Output stage placed directly downstream of the 3-stage SDF NTT pipeline.
- The SDF pipeline emits each N=8 frame in bit-reversed index order. This block collects each frame and re-emits it in natural order.
- Uses ping-pong double buffering: one frame is captured while the previous frame is drained, so back-to-back frames stream with no gap when the sink is always ready.
- Interfaces use valid/ready on both sides.

Parameters:
- data_width, 64, coefficient word width; matches the SDF datapath.
- n_points, 8, frame length; must equal 2**addr_width.
- addr_width, 3, index width; also the number of bits reversed.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  data_width  coefficient from the SDF last stage, bit-reversed order.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  data_width  coefficient in natural order, registered.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts out_data this cycle.
- out_last  output  1  high with out_valid on the final (index n_points-1) word of a frame.
- frame_done_tick  output  1  one-cycle pulse when the last word of a frame is accepted at the output.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_last=0, frame_done_tick=0, out_data=0, in_ready=1.
  - Both banks EMPTY; write bank=0, read bank=0; wcnt=rcnt=0.
  - Bank contents are don't-care.
- Reset mid-frame discards all partial and full frames. The first word accepted after reset is index 0 of a new frame.
- Per-bank state machine:
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL when wcnt=n_points-1 is accepted.
  - FULL -> DRAINING when the read side selects the bank.
  - DRAINING -> EMPTY when the last word of the bank is issued to the output register.
- Write side:
  - Accept when in_valid && in_ready. Store at bank[wb][wcnt], then wcnt++ (wraps to 0).
  - On wrap, toggle wb.
  - in_ready = bank[wb] is EMPTY or FILLING. It is combinational from registered state only.
- Read side:
  - Bank[rb] in FULL/DRAINING issues word k (rcnt) from address bitrev(rcnt), where bit i of the address = bit (addr_width-1-i) of rcnt.
  - Issue happens when out_valid==0 or out_ready==1, i.e. the output register is empty or is being consumed.
  - On issue, rcnt++. On wrap, toggle rb and mark the bank EMPTY.
- Output register:
  - Latency is 1 cycle from issue to out_valid.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - Under continuous ready, throughput is one word per cycle.
- Minimum frame latency: the last input word is accepted at cycle t; word 0 appears on out_valid at t+2, given the bank is FULL at t+1 and issued at t+1.
- Simultaneous events:
  - A write completing bank A and a read draining bank B in the same cycle are both honoured.
  - A bank freed by drain completion becomes writable the next cycle. No same-cycle write into a bank being emptied.
- Both banks FULL: in_ready=0. in_valid is ignored and no data is lost.
- frame_done_tick asserts in the cycle out_valid && out_ready && out_last.
- Arithmetic: pure data movement; no modular arithmetic; words pass unaltered.

Decomposition:
- Shared package ntt_pkg holds:
  - Bank state enum EMPTY/FILLING/FULL/DRAINING.
  - Pure function bitrev(addr, addr_width).
  - Constants N_POINTS and ADDR_WIDTH, kept common with the SDF top and the twiddle ROM.
- One sub-module: ntt_reorder_bank, a simple dual-port register file (1 write port, 1 read port, combinational read, depth n_points). It is instantiated twice.

Test Plan:
- Single frame, sink always ready. Input 0..7 -> out_data 0,4,2,6,1,5,3,7 with out_last on the 8th word, one frame_done_tick, first out_valid 2 cycles after the last input.
- Back-to-back frames. Inputs 0..15 continuous -> outputs 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no bubble between frames and in_ready never low.
- Backpressure. Hold out_ready=0 after 3 output words while feeding 16 inputs -> in_ready drops to 0 once both banks are full. out_data holds its value; releasing ready resumes with no loss or duplication.
- Input gaps. in_valid toggled randomly over one frame of values 100..107 -> output 100,104,102,106,101,105,103,107.
- Async reset mid-frame. Assert rst_n=0 after 5 inputs, then send a fresh frame 0..7 -> all outputs are at reset values during reset. The output is then exactly 0,4,2,6,1,5,3,7 with no stale words.
- Simultaneous fill-complete and drain-complete on opposite banks, with streaming of 3 frames -> all 24 words correct and frame_done_tick pulses exactly 3 times.
